// File: rtl/of_ex_interlock_latch_pkg.sv
// Shared SimpleRisc definitions: opcodes, instruction field positions and
// the OF/EX interlock state type, used by the latch, forwarding and decode.
package of_ex_interlock_latch_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [31:0] NOP_INSTR = 32'h6800_0000;
  localparam logic [3:0]  RA_REG    = 4'hF;

  localparam int OPC_LO  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_LO   = 22;
  localparam int RS1_LO  = 18;
  localparam int RS2_LO  = 14;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2
  } fsm_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_LO +: 5];
  endfunction

  function automatic logic [3:0] rd_of(input logic [31:0] instr);
    return instr[RD_LO +: 4];
  endfunction

  function automatic logic [3:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LO +: 4];
  endfunction

  function automatic logic [3:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LO +: 4];
  endfunction

endpackage

// File: rtl/of_ex_interlock_latch_load_use.sv
// Combinational load-use detector: flags an OF instruction that reads the
// destination of the ld currently sitting in EX.
module load_use_detector
  import of_ex_interlock_latch_pkg::*;
(
  input  logic [31:0] ex_instr,
  input  logic [31:0] of_instr,
  output logic        load_use
);

  logic [4:0] of_op;
  logic [3:0] ld_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       uses_rd;
  logic       uses_ra;
  logic       unused_bits;

  assign unused_bits = ^{ex_instr[IMM_BIT:0], of_instr[RS2_LO-1:0]};

  // Decode which registers the OF instruction reads, then match against ld rd.
  always_comb begin
    of_op    = opcode_of(of_instr);
    ld_rd    = rd_of(ex_instr);
    uses_rs1 = !(of_op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_MOV, OP_NOT});
    uses_rs2 = !of_instr[IMM_BIT] &&
               !(of_op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET,
                               OP_LD, OP_MOV, OP_NOT});
    uses_rd  = (of_op == OP_ST);
    uses_ra  = (of_op == OP_RET);
    if (opcode_of(ex_instr) == OP_LD) begin
      load_use = (uses_rs1 && (rs1_of(of_instr) == ld_rd)) ||
                 (uses_rs2 && (rs2_of(of_instr) == ld_rd)) ||
                 (uses_rd  && (rd_of(of_instr)  == ld_rd)) ||
                 (uses_ra  && (RA_REG           == ld_rd));
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/of_ex_interlock_latch.sv
// OF/EX pipeline latch with load-use bubble insertion, branch squash and
// multicycle-EX hold, plus saturating bubble/squash counters.
module of_ex_interlock_latch
  import of_ex_interlock_latch_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       of_instr,
  input  logic [DATA_W-1:0] of_pc,
  input  logic [DATA_W-1:0] of_op1,
  input  logic [DATA_W-1:0] of_op2,
  input  logic              branch_taken,
  input  logic              ex_busy,
  output logic [31:0]       ex_instr,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic              stall_of,
  output logic              flush_of,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fsm_state_e state_r;
  logic       load_use_raw;
  logic       load_use;

  load_use_detector u_load_use (
    .ex_instr (ex_instr),
    .of_instr (of_instr),
    .load_use (load_use_raw)
  );

  // In BUBBLE the EX slot already holds a nop, so a re-fire is impossible.
  assign load_use = load_use_raw && (state_r != ST_BUBBLE);

  // Interlock controls seen by IF/OF in the current cycle.
  always_comb begin
    flush_of = branch_taken;
    if (branch_taken) begin
      stall_of = 1'b0;
    end else begin
      stall_of = ex_busy || load_use;
    end
  end

  // EX latch, interlock state and counters in priority order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_instr    <= NOP_INSTR;
      ex_pc       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      stall_count <= '0;
      flush_count <= '0;
      state_r     <= ST_RUN;
    end else if (branch_taken) begin
      ex_instr <= NOP_INSTR;
      ex_pc    <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      state_r  <= ST_RUN;
      if (flush_count != CNT_MAX) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end else if (ex_busy) begin
      state_r <= ST_HOLD;
    end else if (load_use) begin
      ex_instr <= NOP_INSTR;
      ex_pc    <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      state_r  <= ST_BUBBLE;
      if (stall_count != CNT_MAX) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end else begin
      ex_instr <= of_instr;
      ex_pc    <= of_pc;
      ex_op1   <= of_op1;
      ex_op2   <= of_op2;
      state_r  <= ST_RUN;
    end
  end

endmodule

// File: tb/tb_of_ex_interlock_latch.sv
// Randomised and directed bench for of_ex_interlock_latch against a
// behavioural pipeline model derived from the interlock rules.
module tb_of_ex_interlock_latch;

  localparam int          CW    = 10;
  localparam int          CMAX  = (1 << CW) - 1;
  localparam logic [31:0] NOP   = 32'h6800_0000;
  localparam logic [31:0] LD_I  = 32'h74C4_0000;  // ld r3,[r1]
  localparam logic [31:0] ADD_I = 32'h010C_8000;  // add r4,r3,r2

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       of_instr, of_pc, of_op1, of_op2;
  logic              branch_taken, ex_busy;
  logic [31:0]       ex_instr, ex_pc, ex_op1, ex_op2;
  logic              stall_of, flush_of;
  logic [CW-1:0]     stall_count, flush_count;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_instr, m_pc, m_op1, m_op2;
  int          m_sc, m_fc;

  always #5 clk = ~clk;

  of_ex_interlock_latch #(
    .DATA_W(32), .NOP_INSTR(32'h6800_0000), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .of_instr(of_instr), .of_pc(of_pc), .of_op1(of_op1), .of_op2(of_op2),
    .branch_taken(branch_taken), .ex_busy(ex_busy),
    .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .stall_of(stall_of), .flush_of(flush_of),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int i, input int rd,
                                      input int rs1, input int rs2);
    return {op[4:0], i[0], rd[3:0], rs1[3:0], rs2[3:0], 14'd0};
  endfunction

  // Registers read by the instruction in OF, per the SimpleRisc source rules.
  function automatic bit hazard(input logic [31:0] ex, input logic [31:0] of);
    int          op;
    logic [3:0]  srcs[$];
    op = int'(of[31:27]);
    if (ex[31:27] != 5'd14) return 1'b0;
    if (!(op inside {13, 18, 16, 17, 19, 9, 8})) srcs.push_back(of[21:18]);
    if (!of[26] && !(op inside {13, 18, 16, 17, 19, 20, 14, 9, 8})) srcs.push_back(of[17:14]);
    if (op == 15) srcs.push_back(of[25:22]);
    if (op == 20) srcs.push_back(4'hF);
    foreach (srcs[k]) if (srcs[k] == ex[25:22]) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural model of the EX slot and counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_instr <= NOP; m_pc <= 0; m_op1 <= 0; m_op2 <= 0; m_sc <= 0; m_fc <= 0;
    end else if (branch_taken) begin
      m_instr <= NOP; m_pc <= 0; m_op1 <= 0; m_op2 <= 0;
      m_fc <= (m_fc == CMAX) ? CMAX : m_fc + 1;
    end else if (ex_busy) begin
      m_instr <= m_instr;
    end else if (hazard(m_instr, of_instr)) begin
      m_instr <= NOP; m_pc <= 0; m_op1 <= 0; m_op2 <= 0;
      m_sc <= (m_sc == CMAX) ? CMAX : m_sc + 1;
    end else begin
      m_instr <= of_instr; m_pc <= of_pc; m_op1 <= of_op1; m_op2 <= of_op2;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("ex_instr", ex_instr, m_instr);
      check("ex_pc", ex_pc, m_pc);
      check("ex_op1", ex_op1, m_op1);
      check("ex_op2", ex_op2, m_op2);
      check("stall_count", stall_count, m_sc);
      check("flush_count", flush_count, m_fc);
      check("stall_of", stall_of, !branch_taken && (ex_busy || hazard(m_instr, of_instr)));
      check("flush_of", flush_of, branch_taken);
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic bt, input logic busy);
    @(posedge clk);
    #1;
    of_instr = ins; of_pc = pc; of_op1 = pc ^ 32'hA5A5_0000; of_op2 = pc + 32'd7;
    branch_taken = bt; ex_busy = busy;
  endtask

  function automatic logic [31:0] rand_instr();
    int op, r;
    op = ($urandom_range(0, 3) == 0) ? 14 : $urandom_range(0, 20);
    r  = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
    return enc(op, $urandom_range(0, 1), r, $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0; of_instr = NOP; of_pc = 0; of_op1 = 0; of_op2 = 0;
    branch_taken = 1'b0; ex_busy = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_instr", ex_instr, 32'h6800_0000);
    check("reset_stall_of", stall_of, 1'b0);
    check("reset_flush_of", flush_of, 1'b0);
    check("reset_counts", {stall_count, flush_count}, '0);
    cmp_en = 1'b1;

    // Load-use: one bubble, then the stalled add enters EX.
    drive(LD_I, 32'h100, 1'b0, 1'b0);
    drive(ADD_I, 32'h104, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_ld_in_ex", ex_instr, LD_I);
    check("lu_stall", stall_of, 1'b1);
    @(negedge clk);
    check("lu_bubble", ex_instr, NOP);
    check("lu_stall_count", stall_count, 1);
    check("lu_bubble_pc", ex_pc, 0);
    @(negedge clk);
    check("lu_add_latched", ex_instr, ADD_I);
    check("lu_add_pc", ex_pc, 32'h104);

    // No hazard: add r4,r5,r2 behind ld r3.
    drive(LD_I, 32'h200, 1'b0, 1'b0);
    drive(enc(0, 0, 4, 5, 2), 32'h204, 1'b0, 1'b0);
    @(negedge clk);
    check("nh_stall", stall_of, 1'b0);
    @(negedge clk);
    check("nh_latched", ex_instr, enc(0, 0, 4, 5, 2));
    check("nh_stall_count", stall_count, 1);

    // Branch in the same cycle as a load-use hazard.
    drive(LD_I, 32'h300, 1'b0, 1'b0);
    drive(ADD_I, 32'h304, 1'b1, 1'b0);
    @(negedge clk);
    check("br_flush", flush_of, 1'b1);
    check("br_stall", stall_of, 1'b0);
    drive(ADD_I, 32'h304, 1'b0, 1'b0);
    @(negedge clk);
    check("br_nop", ex_instr, NOP);
    check("br_flush_count", flush_count, 1);
    check("br_stall_count", stall_count, 1);

    // Multicycle hold for three cycles with div in EX.
    drive(enc(3, 0, 6, 1, 2), 32'h400, 1'b0, 1'b0);
    drive(enc(1, 0, 7, 8, 9), 32'h404, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_instr", ex_instr, enc(3, 0, 6, 1, 2));
      check("hold_pc", ex_pc, 32'h400);
      check("hold_stall", stall_of, 1'b1);
      drive(enc(1, 0, 7, 8, 9), 32'h404, 1'b0, (k < 2) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check("hold_still", ex_instr, enc(3, 0, 6, 1, 2));
    @(negedge clk);
    check("hold_release", ex_instr, enc(1, 0, 7, 8, 9));

    // Saturation of the bubble counter.
    for (int n = 0; n < CMAX + 6; n++) begin
      drive(LD_I, 32'h500, 1'b0, 1'b0);
      drive(ADD_I, 32'h504, 1'b0, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    check("sat_stall_count", stall_count, CMAX);
    drive(LD_I, 32'h500, 1'b0, 1'b0);
    drive(ADD_I, 32'h504, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("sat_stays", stall_count, CMAX);

    // Randomised traffic with a mid-cycle reset partway through.
    for (int c = 0; c < 3000; c++) begin
      drive(rand_instr(), $urandom, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) == 0));
      if (c == 1500) begin
        #2;
        branch_taken = 1'b0; ex_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_instr", ex_instr, 32'h6800_0000);
        check("midreset_pc", ex_pc, 0);
        check("midreset_counts", {stall_count, flush_count}, '0);
        check("midreset_ctl", {stall_of, flush_of}, 2'b00);
        #3 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
